i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 Parameter ACK_HOLD, default 300: number of clk cycles after a synced SCL rise at which a write-data ACK is released if SCL has not yet fallen.
REQ-003 Port list:
- clk  input  1  system clock, 40 MHz nominal.
- rst  input  1  synchronous active-high reset.
- scl  input  1  I2C clock from the initiator.
- sda  inout  1  I2C data; the block drives only 0 or Z, and the bench supplies the pull-up.
- busy  output  1  high from START detect until STOP detect.
- done  output  1  one-cycle pulse on STOP detect after a complete transaction.
- mem_we  output  1  one-cycle pulse when a written byte is committed to memory.
- last_addr  output  7  address field of the most recent transaction.
- last_data  output  8  byte most recently written or read out.
- last_op  output  1  R/W bit of the most recent transaction (1 = read).

Function
REQ-004 scl and sda SHALL pass through 2-flop synchronizers; all edge, START and STOP detection SHALL use the synced values, giving 2-cycle latency.
REQ-005 START SHALL be detected as a synced-sda fall while synced-scl is high; STOP as a synced-sda rise while synced-scl is high.
REQ-006 Storage SHALL be a 128x8 array indexed by the 7-bit address field; there is no device-address match, and every address is ACKed.
REQ-007 FSM states SHALL be IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-008 START in any state SHALL clear the bit counter, release sda, set busy=1 and enter ADDR (repeated START is supported).
REQ-009 STOP in any state SHALL release sda, set busy=0 and enter IDLE; done SHALL pulse only if the FSM was in WAIT_STOP or RD_ACK.
REQ-010 ADDR: on each synced SCL rise, shift synced sda in MSB first; after the 8th rise, latch last_addr and last_op.
REQ-011 ADDR_ACK: on the SCL fall after the 8th rise, drive sda=0; on the next fall, release sda and go to WR_DATA (op=0) or RD_DATA (op=1).
REQ-012 In RD_DATA, on that same fall, the block SHALL drive bit 7 of mem[addr] (0 -> drive low, 1 -> Z) and set last_data=mem[addr].
REQ-013 WR_DATA: shift in 8 bits on SCL rises, MSB first; after the 8th rise, write mem[addr], pulse mem_we and update last_data in the same cycle.
REQ-014 WR_ACK: drive sda=0 on the SCL fall after the 8th data rise.
REQ-015 WR_ACK release: sda SHALL be released on the next SCL fall, or when synced-scl has been high for ACK_HOLD cycles, whichever comes first; then go to WAIT_STOP.
REQ-016 RD_DATA: on each SCL fall, present the next bit MSB-first, so each bit is stable from the fall until the next fall.
REQ-017 RD_DATA end: on the fall after the 8th bit's SCL high phase, release sda and enter RD_ACK.
REQ-018 RD_ACK: sample the initiator ACK/NACK on the SCL rise and ignore its value; then go to WAIT_STOP.
REQ-019 WAIT_STOP: sda SHALL stay released and further SCL edges are ignored; only START or STOP exits this state.
REQ-020 The block SHALL never drive sda to 1, and SHALL never change its own sda drive while synced-scl is high, except for the ACK_HOLD release in REQ-015.
REQ-021 SCL edges seen in IDLE SHALL be ignored.

Reset
REQ-022 On rst: state=IDLE, sda released, busy=0, done=0, mem_we=0, last_addr=0, last_data=0, last_op=0, bit counter=0, synchronizers=1, mem[i]=i for i=0..127.
REQ-023 A reset asserted mid-transaction SHALL take effect on the next clk edge; the block SHALL then ignore the bus until the next START.

Verification
REQ-024 Write addr 0x15, data 0xA5 at a 100 kHz SCL -> sda low during both ACK clocks; mem_we pulses once; mem[0x15]=0xA5; last_op=0; done pulses once after STOP; busy=0.
REQ-025 After reset, read addr 0x0C -> bits 00001100 appear on sda MSB-first across the 8 SCL highs; last_data=0x0C; sda released during the 9th clock; done pulses.
REQ-026 Write 0x3C to addr 0x7F, then read addr 0x7F -> byte received is 0x3C; no spurious STOP or extra done during the WR_ACK-to-STOP sequence.
REQ-027 START, 4 address bits, then repeated START, then a full write of 0x5A to addr 0x01 -> only addr 0x01 is written; mem_we pulses once.
REQ-028 rst asserted during RD_DATA bit 3 -> sda released and busy=0 on the next cycle; mem[] returns to its reset contents; the next full transaction completes normally.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target with a 128x8 register file: every 7-bit address is ACKed and
// selects one byte, which is written on a write transfer or returned on a read.
module i2c_target #(
    parameter int ACK_HOLD = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    inout  wire        sda,
    output logic       busy,
    output logic       done,
    output logic       mem_we,
    output logic [6:0] last_addr,
    output logic [7:0] last_data,
    output logic       last_op
);

    localparam int HOLD_W = $clog2(ACK_HOLD + 1);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
    } state_e;

    state_e            state_q, state_d;
    logic              scl_meta_q, scl_sync_q, scl_prev_q;
    logic              sda_meta_q, sda_sync_q, sda_prev_q;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              sda_oe_q, sda_oe_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              done_q, done_d;
    logic              mem_we_q, mem_we_d;
    logic [6:0]        last_addr_q, last_addr_d;
    logic [7:0]        last_data_q, last_data_d;
    logic              last_op_q, last_op_d;
    logic [7:0]        mem_q [128];

    logic [7:0] rx_byte;
    logic [7:0] mem_rd;
    logic       scl_rise, scl_fall, start_det, stop_det, hold_expired;

    // Synchronizers idle high so a reset never looks like a bus edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= scl;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    assign scl_rise     = scl_sync_q & ~scl_prev_q;
    assign scl_fall     = ~scl_sync_q & scl_prev_q;
    assign start_det    = scl_sync_q & sda_prev_q & ~sda_sync_q;
    assign stop_det     = scl_sync_q & ~sda_prev_q & sda_sync_q;
    assign rx_byte      = {shift_q[6:0], sda_sync_q};
    assign mem_rd       = mem_q[last_addr_q];
    assign hold_expired = scl_sync_q && (hold_cnt_q == HOLD_W'(ACK_HOLD - 1));

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        sda_oe_d    = sda_oe_q;
        hold_cnt_d  = hold_cnt_q;
        done_d      = 1'b0;
        mem_we_d    = 1'b0;
        last_addr_d = last_addr_q;
        last_data_d = last_data_q;
        last_op_d   = last_op_q;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            done_d   = (state_q == WAIT_STOP) || (state_q == RD_ACK);
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        if (bit_cnt_q == 3'd7) begin
                            last_addr_d = rx_byte[7:1];
                            last_op_d   = rx_byte[0];
                            bit_cnt_d   = 3'd0;
                            state_d     = ADDR_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                // The drive flag doubles as the phase marker: first fall pulls low, second ends the ACK.
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else if (last_op_q) begin
                            shift_d     = mem_rd;
                            sda_oe_d    = ~mem_rd[7];
                            last_data_d = mem_rd;
                            state_d     = RD_DATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        if (bit_cnt_q == 3'd7) begin
                            mem_we_d    = 1'b1;
                            last_data_d = rx_byte;
                            bit_cnt_d   = 3'd0;
                            hold_cnt_d  = '0;
                            state_d     = WR_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                // Release early if the initiator parks SCL high for ACK_HOLD cycles.
                WR_ACK: begin
                    if (!sda_oe_q) begin
                        hold_cnt_d = '0;
                        if (scl_fall) begin
                            sda_oe_d = 1'b1;
                        end
                    end else if (scl_fall || hold_expired) begin
                        sda_oe_d = 1'b0;
                        state_d  = WAIT_STOP;
                    end else if (scl_sync_q) begin
                        hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd0;
                            state_d   = RD_ACK;
                        end else begin
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        state_d = WAIT_STOP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            sda_oe_q    <= 1'b0;
            hold_cnt_q  <= '0;
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            last_addr_q <= 7'd0;
            last_data_q <= 8'd0;
            last_op_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            sda_oe_q    <= sda_oe_d;
            hold_cnt_q  <= hold_cnt_d;
            done_q      <= done_d;
            mem_we_q    <= mem_we_d;
            last_addr_q <= last_addr_d;
            last_data_q <= last_data_d;
            last_op_q   <= last_op_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) begin
                mem_q[i] <= 8'(i);
            end
        end else if (mem_we_d) begin
            mem_q[last_addr_q] <= rx_byte;
        end
    end

    assign sda       = sda_oe_q ? 1'b0 : 1'bz;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign mem_we    = mem_we_q;
    assign last_addr = last_addr_q;
    assign last_data = last_data_q;
    assign last_op   = last_op_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged initiator, a transaction-level model of the
// target's register file and status outputs, and one per-cycle compare process.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam int SETTLE   = 6;
    localparam int SEL_ADDR = 0;
    localparam int SEL_DATA = 1;
    localparam int SEL_OP   = 2;
    localparam int SEL_BUSY = 3;
    localparam int SEL_SDA  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_drv = 1'b1;
    logic       sda_low = 1'b0;
    wire        sda;
    logic       busy, done, mem_we, last_op;
    logic [6:0] last_addr;
    logic [7:0] last_data;

    pullup (sda);
    assign sda = sda_low ? 1'b0 : 1'bz;

    i2c_target dut (
        .clk       (clk),
        .rst       (rst),
        .scl       (scl_drv),
        .sda       (sda),
        .busy      (busy),
        .done      (done),
        .mem_we    (mem_we),
        .last_addr (last_addr),
        .last_data (last_data),
        .last_op   (last_op)
    );

    always #12.5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state, written only by the initiator process.
    logic [7:0]  exp_mem [128];
    logic        m_busy = 1'b0;
    logic [6:0]  m_addr = 7'd0;
    logic [7:0]  m_data = 8'd0;
    logic        m_op = 1'b0;
    logic        m_armed = 1'b0;
    int          m_done = 0;
    int          m_we = 0;
    int          ev_cyc = 0;
    bit          started = 1'b0;
    bit          skip_chk = 1'b0;
    int          q = 25;

    // One-shot literal checks handed to the compare process.
    int          chk_cyc = -1;
    int          chk_sel = 0;
    logic [31:0] chk_exp = '0;
    string       chk_name = "";

    // Written only by the compare process.
    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int we_cnt = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (done === 1'b1) done_cnt++;
            if (mem_we === 1'b1) we_cnt++;
        end
        if (cyc == chk_cyc) begin
            case (chk_sel)
                SEL_ADDR: check(chk_name, 32'(last_addr), chk_exp);
                SEL_DATA: check(chk_name, 32'(last_data), chk_exp);
                SEL_OP:   check(chk_name, 32'(last_op), chk_exp);
                SEL_BUSY: check(chk_name, 32'(busy), chk_exp);
                default:  check(chk_name, 32'(sda), chk_exp);
            endcase
        end
        if (started && !rst && !skip_chk && (cyc - ev_cyc > SETTLE)) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("last_addr", 32'(last_addr), 32'(m_addr));
            check("last_data", 32'(last_data), 32'(m_data));
            check("last_op", 32'(last_op), 32'(m_op));
            check("done_count", 32'(done_cnt), 32'(m_done));
            check("mem_we_count", 32'(we_cnt), 32'(m_we));
        end
    end

    task automatic wait_clks(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic mark();
        ev_cyc = cyc;
    endtask

    task automatic post(int sel, logic [31:0] exp, string name);
        chk_sel  = sel;
        chk_exp  = exp;
        chk_name = name;
        chk_cyc  = cyc + 1;
        wait_clks(2);
    endtask

    task automatic reset_model();
        m_busy  = 1'b0;
        m_addr  = 7'd0;
        m_data  = 8'd0;
        m_op    = 1'b0;
        m_armed = 1'b0;
        for (int i = 0; i < 128; i++) exp_mem[i] = 8'(i);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        reset_model();
        wait_clks(2);
        rst = 1'b0;
        started = 1'b1;
        mark();
    endtask

    task automatic i2c_start();
        sda_low = 1'b0;
        wait_clks(q);
        scl_drv = 1'b1;
        wait_clks(q);
        sda_low = 1'b1;
        m_busy  = 1'b1;
        m_armed = 1'b0;
        mark();
        wait_clks(q);
        scl_drv = 1'b0;
        wait_clks(q);
    endtask

    task automatic i2c_stop();
        sda_low = 1'b1;
        wait_clks(q);
        scl_drv = 1'b1;
        wait_clks(q);
        sda_low = 1'b0;
        if (m_busy && m_armed) m_done++;
        m_busy  = 1'b0;
        m_armed = 1'b0;
        mark();
        wait_clks(q);
    endtask

    // Initiator drives the first n bits of b; the 8th rise completes a byte.
    task automatic send_bits(logic [7:0] b, int n, bit is_addr);
        for (int i = 0; i < n; i++) begin
            sda_low = ~b[7-i];
            wait_clks(q);
            scl_drv = 1'b1;
            if (i == 7) begin
                if (is_addr) begin
                    m_addr = b[7:1];
                    m_op   = b[0];
                end else begin
                    exp_mem[m_addr] = b;
                    m_data = b;
                    m_we++;
                end
                mark();
            end
            wait_clks(2 * q);
            scl_drv = 1'b0;
            wait_clks(q);
        end
    endtask

    task automatic ack_clock(bit addr_phase, string name);
        sda_low = 1'b0;
        wait_clks(q);
        scl_drv = 1'b1;
        wait_clks(q);
        post(SEL_SDA, 32'd0, name);
        wait_clks(q - 2);
        scl_drv = 1'b0;
        if (addr_phase && m_op) begin
            m_data = exp_mem[m_addr];
            mark();
        end
        if (!addr_phase) m_armed = 1'b1;
        wait_clks(q);
    endtask

    // Data ACK clock with SCL parked high: the target lets go on its own, which
    // the bus sees as a STOP while the target waits for one.
    task automatic ack_clock_hold();
        sda_low = 1'b0;
        wait_clks(q);
        skip_chk = 1'b1;
        scl_drv  = 1'b1;
        wait_clks(100);
        post(SEL_SDA, 32'd0, "hold_ack_still_low");
        wait_clks(228);
        post(SEL_SDA, 32'd1, "hold_ack_released");
        m_busy = 1'b0;
        m_done++;
        m_armed = 1'b0;
        mark();
        skip_chk = 1'b0;
        wait_clks(70);
        scl_drv = 1'b0;
        wait_clks(q);
    endtask

    task automatic read_bits(int n);
        logic [7:0] e;
        e = exp_mem[m_addr];
        for (int i = 0; i < n; i++) begin
            sda_low = 1'b0;
            wait_clks(q);
            scl_drv = 1'b1;
            wait_clks(q);
            post(SEL_SDA, 32'(e[7-i]), "rd_bit");
            wait_clks(q - 2);
            scl_drv = 1'b0;
            if (i == 7) m_armed = 1'b1;
            wait_clks(q);
        end
    endtask

    task automatic nack_clock();
        sda_low = 1'b0;
        wait_clks(q);
        scl_drv = 1'b1;
        wait_clks(q);
        post(SEL_SDA, 32'd1, "rd_9th_released");
        wait_clks(q - 2);
        scl_drv = 1'b0;
        wait_clks(q);
    endtask

    task automatic write_txn(logic [6:0] a, logic [7:0] d);
        i2c_start();
        send_bits({a, 1'b0}, 8, 1'b1);
        ack_clock(1'b1, "wr_addr_ack");
        send_bits(d, 8, 1'b0);
        ack_clock(1'b0, "wr_data_ack");
        i2c_stop();
    endtask

    task automatic read_txn(logic [6:0] a);
        i2c_start();
        send_bits({a, 1'b1}, 8, 1'b1);
        ack_clock(1'b1, "rd_addr_ack");
        read_bits(8);
        nack_clock();
        i2c_stop();
    endtask

    initial begin
        q = 25;
        wait_clks(3);
        do_reset();
        wait_clks(4);
        post(SEL_ADDR, 32'h00, "reset_last_addr");
        post(SEL_DATA, 32'h00, "reset_last_data");
        post(SEL_OP,   32'h0,  "reset_last_op");
        post(SEL_BUSY, 32'h0,  "reset_busy");
        post(SEL_SDA,  32'h1,  "reset_sda_released");

        // Write 0x15 <- 0xA5 at 100 kHz, then read it back.
        q = 100;
        write_txn(7'h15, 8'hA5);
        wait_clks(10);
        post(SEL_DATA, 32'hA5, "w15_last_data");
        post(SEL_ADDR, 32'h15, "w15_last_addr");
        post(SEL_OP,   32'h0,  "w15_last_op");
        post(SEL_BUSY, 32'h0,  "w15_busy");
        q = 25;
        read_txn(7'h15);
        wait_clks(10);
        post(SEL_DATA, 32'hA5, "r15_readback");

        // Fresh reset, then read the reset contents of 0x0C.
        do_reset();
        wait_clks(10);
        read_txn(7'h0C);
        wait_clks(10);
        post(SEL_DATA, 32'h0C, "r0c_last_data");
        post(SEL_OP,   32'h1,  "r0c_last_op");

        // Top address round trip.
        write_txn(7'h7F, 8'h3C);
        read_txn(7'h7F);
        wait_clks(10);
        post(SEL_DATA, 32'h3C, "r7f_last_data");
        post(SEL_ADDR, 32'h7F, "r7f_last_addr");

        // Aborted address phase followed by a repeated START.
        i2c_start();
        send_bits(8'hFE, 4, 1'b1);
        write_txn(7'h01, 8'h5A);
        read_txn(7'h01);
        wait_clks(10);
        post(SEL_ADDR, 32'h01, "rs_last_addr");
        post(SEL_DATA, 32'h5A, "rs_last_data");

        // Data ACK released by the hold timer.
        i2c_start();
        send_bits({7'h20, 1'b0}, 8, 1'b1);
        ack_clock(1'b1, "hold_addr_ack");
        send_bits(8'h33, 8, 1'b0);
        ack_clock_hold();
        i2c_stop();
        read_txn(7'h20);
        wait_clks(10);
        post(SEL_DATA, 32'h33, "hold_readback");

        // Reset while the target drives bit 3 of a read byte (0x05 -> 0000_0101).
        i2c_start();
        send_bits({7'h05, 1'b1}, 8, 1'b1);
        ack_clock(1'b1, "mid_addr_ack");
        read_bits(3);
        sda_low = 1'b0;
        wait_clks(q);
        scl_drv = 1'b1;
        wait_clks(q);
        post(SEL_SDA, 32'd0, "mid_bit3_driven");
        rst = 1'b1;
        reset_model();
        mark();
        post(SEL_SDA, 32'd1, "mid_rst_sda_released");
        post(SEL_BUSY, 32'd0, "mid_rst_busy");
        rst = 1'b0;
        mark();
        wait_clks(q);
        scl_drv = 1'b0;
        wait_clks(q);
        send_bits(8'h60, 3, 1'b0);
        read_txn(7'h7F);
        wait_clks(10);
        post(SEL_DATA, 32'h7F, "post_rst_mem_restored");
        post(SEL_BUSY, 32'h0,  "post_rst_busy");

        wait_clks(20);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
